// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for the generic pipeline stage register: exception codes,
// the default handler PC and the bit layout of a stored stage entry.
package pipe_stage_skid_pkg;

  localparam logic [31:0] EXC_PC_DEFAULT = 32'h0000_4180;

  typedef enum logic [4:0] {
    EXC_NONE = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_OV   = 5'd12
  } exc_code_e;

  // Entry layout, LSB first: valid, bubble, bd, exc[EXC_W], pc[PC_W], data[DATA_W]
  localparam int unsigned ENT_VALID   = 0;
  localparam int unsigned ENT_BUBBLE  = 1;
  localparam int unsigned ENT_BD      = 2;
  localparam int unsigned ENT_EXC_LSB = 3;

  function automatic int unsigned ent_pc_lsb(input int unsigned exc_w);
    return ENT_EXC_LSB + exc_w;
  endfunction

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (clear) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic inter-stage register with valid/ready handshake and a 1-entry skid
// buffer, flush-as-bubble, exception kill and stall/bubble counters.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int unsigned     DATA_W = 64,
  parameter int unsigned     PC_W   = 32,
  parameter int unsigned     EXC_W  = 5,
  parameter logic [PC_W-1:0] EXC_PC = PC_W'(EXC_PC_DEFAULT),
  parameter int unsigned     CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [EXC_W-1:0]  in_exc,
  input  logic              in_bd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [PC_W-1:0]   out_pc,
  output logic [EXC_W-1:0]  out_exc,
  output logic              out_bd,
  output logic              out_bubble,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam int unsigned PC_LSB   = ent_pc_lsb(EXC_W);
  localparam int unsigned DATA_LSB = PC_LSB + PC_W;
  localparam int unsigned ENT_W    = DATA_LSB + DATA_W;

  logic [ENT_W-1:0] main_q, main_d;
  logic [ENT_W-1:0] skid_q, skid_d;
  logic [ENT_W-1:0] inc_ent;
  logic             in_ready_q;
  logic             in_fire, out_fire;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = main_q[ENT_VALID] & out_ready;

  always_comb begin
    inc_ent                           = '0;
    inc_ent[ENT_VALID]                = 1'b1;
    inc_ent[ENT_BUBBLE]               = flush;
    inc_ent[ENT_BD]                   = in_bd;
    inc_ent[ENT_EXC_LSB +: EXC_W]     = in_exc;
    inc_ent[PC_LSB +: PC_W]           = in_pc;
    inc_ent[DATA_LSB +: DATA_W]       = flush ? '0 : in_data;
  end

  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (req) begin
      main_d                        = '0;
      main_d[ENT_EXC_LSB +: EXC_W]  = EXC_W'(EXC_NONE);
      main_d[PC_LSB +: PC_W]        = EXC_PC;
      skid_d                        = '0;
    end else if (!main_q[ENT_VALID] || out_fire) begin
      if (skid_q[ENT_VALID]) begin
        main_d             = skid_q;
        skid_d[ENT_VALID]  = 1'b0;
      end else if (in_fire) begin
        main_d = inc_ent;
      end else begin
        // Emptied main keeps pc/exc/bd/bubble for visibility; only payload is scrubbed.
        main_d[ENT_VALID]            = 1'b0;
        main_d[DATA_LSB +: DATA_W]   = '0;
      end
    end else if (in_fire) begin
      skid_d = inc_ent;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= ~skid_d[ENT_VALID];
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (~req & main_q[ENT_VALID] & ~out_ready),
    .cnt   (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (~req & flush & in_fire),
    .cnt   (bubble_cnt)
  );

  assign in_ready   = in_ready_q;
  assign out_valid  = main_q[ENT_VALID];
  assign out_bubble = main_q[ENT_BUBBLE];
  assign out_bd     = main_q[ENT_BD];
  assign out_exc    = main_q[ENT_EXC_LSB +: EXC_W];
  assign out_pc     = main_q[PC_LSB +: PC_W];
  assign out_data   = main_q[DATA_LSB +: DATA_W];
  assign occupancy  = {1'b0, main_q[ENT_VALID]} + {1'b0, skid_q[ENT_VALID]};

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: directed beats, stalls, flush, req, reset
// and stall-counter saturation with a 4-bit counter.
module tb_pipe_stage_skid;

  localparam int unsigned DW = 64;
  localparam int unsigned PW = 32;
  localparam int unsigned EW = 5;
  localparam int unsigned CW = 4;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [PW-1:0] pc;
    logic [EW-1:0] exc;
    logic          bd;
    logic          bub;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset, req, flush, in_valid, in_ready, in_bd;
  logic [DW-1:0] in_data, out_data;
  logic [PW-1:0] in_pc, out_pc;
  logic [EW-1:0] in_exc, out_exc;
  logic          out_valid, out_ready, out_bd, out_bubble;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cnt, bubble_cnt;

  int    checks = 0;
  int    errors = 0;
  beat_t exp_q[$];

  pipe_stage_skid #(
    .DATA_W (DW),
    .PC_W   (PW),
    .EXC_W  (EW),
    .EXC_PC (32'h0000_4180),
    .CNT_W  (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_pc      (in_pc),
    .in_exc     (in_exc),
    .in_bd      (in_bd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_pc     (out_pc),
    .out_exc    (out_exc),
    .out_bd     (out_bd),
    .out_bubble (out_bubble),
    .occupancy  (occupancy),
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock of stimulus; accepted beats are scored at the negedge before the edge.
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [PW-1:0] pc,
                       input logic [EW-1:0] exc, input logic b, input logic fl,
                       input logic rq, input logic rst, input logic ordy);
    beat_t e;
    reset = rst; req = rq; flush = fl; in_valid = v;
    in_data = d; in_pc = pc; in_exc = exc; in_bd = b; out_ready = ordy;
    @(negedge clk);
    if (v && in_ready && !rq && !rst) begin
      e.data = fl ? '0 : d;
      e.pc   = pc;
      e.exc  = exc;
      e.bd   = b;
      e.bub  = fl;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (rq || rst) exp_q.delete();
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, ordy);
  endtask

  always @(negedge clk) begin
    beat_t e, a;
    if (reset === 1'b0 && req === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      a = {out_data, out_pc, out_exc, out_bd, out_bubble};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: got %0h expected none", a);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL beat_order: got %0h expected %0h", a, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; req = 1'b0; flush = 1'b0; in_valid = 1'b0; in_bd = 1'b0;
    in_data = '0; in_pc = '0; in_exc = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_bubble_cnt", bubble_cnt, 0);

    // back-to-back streaming
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 64'h1111_0000_0000_0000 + 64'(i), 32'h3000 + 32'(4 * i), 5'd0,
            1'(i % 2), 1'b0, 1'b0, 1'b0, 1'b1);
      if (i == 0) begin
        chk("latency_valid", out_valid, 1);
        chk("latency_pc", out_pc, 32'h3000);
      end
      chk("stream_in_ready", in_ready, 1);
      chk("stream_occ_le1", (occupancy <= 2'd1), 1);
    end
    idle(1'b1);
    chk("drain_out_valid", out_valid, 0);
    chk("drain_out_data", out_data, 0);
    chk("stream_stall_cnt", stall_cnt, 0);
    chk("stream_q_empty", exp_q.size(), 0);

    // back-pressure fills the skid entry
    drive(1'b1, 64'hA0, 32'h3000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("bp1_in_ready", in_ready, 1);
    chk("bp1_occ", occupancy, 1);
    drive(1'b1, 64'hA4, 32'h3004, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("bp2_in_ready", in_ready, 0);
    chk("bp2_occ", occupancy, 2);
    drive(1'b1, 64'hA8, 32'h3008, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 64'hA8, 32'h3008, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("bp_stall_cnt", stall_cnt, 3);
    chk("bp_occ_hold", occupancy, 2);
    idle(1'b1);
    chk("bp_release_pc", out_pc, 32'h3004);
    chk("bp_release_in_ready", in_ready, 1);
    idle(1'b1);
    idle(1'b1);
    chk("bp_q_empty", exp_q.size(), 0);
    chk("bp_stall_hold", stall_cnt, 3);

    // flush converts the beat into a bubble
    drive(1'b1, 64'hDEAD, 32'h3010, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("flush_data", out_data, 0);
    chk("flush_pc", out_pc, 32'h3010);
    chk("flush_exc", out_exc, 4);
    chk("flush_bd", out_bd, 1);
    chk("flush_bubble", out_bubble, 1);
    chk("flush_bubble_cnt", bubble_cnt, 1);
    drive(1'b0, 64'hBEEF, 32'h3014, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("flush_nofire_cnt", bubble_cnt, 1);
    chk("flush_nofire_valid", out_valid, 0);

    // req with flush while both entries are full
    drive(1'b1, 64'hC0, 32'h3020, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 64'hC4, 32'h3024, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("req_pre_occ", occupancy, 2);
    drive(1'b1, 64'hC8, 32'h3028, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("req_out_valid", out_valid, 0);
    chk("req_out_pc", out_pc, 32'h0000_4180);
    chk("req_out_exc", out_exc, 0);
    chk("req_out_bd", out_bd, 0);
    chk("req_out_bubble", out_bubble, 0);
    chk("req_out_data", out_data, 0);
    chk("req_occ", occupancy, 0);
    chk("req_in_ready", in_ready, 1);
    chk("req_stall_hold", stall_cnt, 4);
    chk("req_bubble_hold", bubble_cnt, 1);

    // reset in the middle of a stall
    drive(1'b1, 64'hD0, 32'h3030, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    chk("mid_stall_cnt", stall_cnt, 6);
    drive(1'b1, 64'hD4, 32'h3034, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("mrst_stall_cnt", stall_cnt, 0);
    chk("mrst_bubble_cnt", bubble_cnt, 0);
    chk("mrst_occ", occupancy, 0);
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_out_pc", out_pc, 0);
    chk("mrst_in_ready", in_ready, 1);

    // stall counter saturation
    drive(1'b1, 64'hE0, 32'h3040, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) idle(1'b0);
    chk("sat_stall_cnt", stall_cnt, 15);
    idle(1'b0);
    chk("sat_stall_hold", stall_cnt, 15);
    idle(1'b1);
    idle(1'b1);
    chk("sat_q_empty", exp_q.size(), 0);
    chk("sat_out_valid", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed-field inter-stage pipeline registers: one generic stage register for any D/E/M/W boundary.
- Adds a valid/ready handshake with a 1-entry skid buffer, so in_ready is registered and back-pressure never forms a combinational path across the stage.
- Keeps the team's flush-as-bubble semantics: PC, exception code and delay-slot flag are retained.
- Keeps exception-request kill semantics: the stage is cleared and the handler PC is injected.
- Adds saturating stall and bubble counters for performance monitoring.

Parameters:
DATA_W, 64, width of opaque control+data payload
PC_W, 32, PC width
EXC_W, 5, exception code width
EXC_PC, 32'h0000_4180, PC presented after exception request
CNT_W, 16, width of stall/bubble counters

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
req  in  1  exception request: kill stage
flush  in  1  convert incoming beat to bubble
in_valid  in  1  upstream beat valid
in_ready  out  1  stage can accept (registered)
in_data  in  DATA_W  payload
in_pc  in  PC_W  beat PC
in_exc  in  EXC_W  accumulated exception code
in_bd  in  1  branch-delay-slot flag
out_valid  out  1  main entry holds a beat
out_ready  in  1  downstream accepts
out_data  out  DATA_W  payload
out_pc  out  PC_W  beat PC
out_exc  out  EXC_W  exception code
out_bd  out  1  delay-slot flag
out_bubble  out  1  beat is a flush bubble
occupancy  out  2  entries held (0..2)
stall_cnt  out  CNT_W  cycles with out_valid & ~out_ready (saturating)
bubble_cnt  out  CNT_W  bubbles accepted (saturating)

Behaviour:
- Storage: main entry (drives out_*) and skid entry. Each entry = {valid, bubble, data, pc, exc, bd}.
- Definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - in_ready = ~skid.valid, registered.
- Priority: reset > req > flush > normal. All updates occur on the posedge clk.
- reset: both entries invalid; all fields 0; out_pc=0; occupancy=0; counters=0; in_ready=1 the next cycle.
- req:
  - Both entries are invalidated and the input beat is dropped.
  - Next cycle: out_valid=0, out_data=0, out_exc=0, out_bd=0, out_bubble=0, out_pc=EXC_PC.
  - Counters hold.
- flush:
  - Acts only on an accepted beat (in_fire).
  - The accepted entry gets data=0, bubble=1, valid=1; pc, exc and bd are copied from the input.
  - Existing entries are untouched.
  - bubble_cnt increments once per flushed in_fire.
  - flush without in_fire has no effect.
- Normal data movement:
  - If main is empty or out_fire:
    - If skid is valid: main<=skid, skid invalid.
    - Else if in_fire: main<=incoming.
    - Else: main invalid; data fields hold their old values, except out_data, which is zeroed.
  - Else, if in_fire: skid<=incoming. Main is full and stalled, and skid was empty by in_ready.
  - Skid valid and in_fire never coincide.
- Latency: 1 cycle in->out when empty. Full throughput (1 beat/cycle) with out_ready held high.
- stall_cnt increments each cycle with out_valid & ~out_ready. It saturates at all-ones and does not wrap.
- Simultaneous events:
  - req with flush or any fire: req wins; nothing is accepted or emitted.
  - out_fire with in_fire while skid is empty: main is replaced by the incoming beat, with no bubble cycle.
- occupancy = main.valid + skid.valid.
- Data ordering is strictly FIFO. No beat is duplicated or lost except by req or reset.

Decomposition:
- Shared package holds: EXC_PC default, exception code constants (EXC_NONE=0), and the stage-entry field layout (offsets/widths of valid, bubble, exc, bd).
- One natural sub-module: sat_counter (parametrised CNT_W, inc, clear), instantiated twice.
- Entry storage stays inline.

Test Plan:
- Reset, then 4 back-to-back beats (pc 0x3000, 0x3004, 0x3008, 0x300C) with out_ready=1 -> each appears 1 cycle later; in_ready stays 1; occupancy<=1; stall_cnt=0.
- out_ready=0 for 3 cycles while beats pc 0x3000, 0x3004 arrive:
  - in_ready drops after the second beat; occupancy=2; stall_cnt=3.
  - Releasing out_ready -> 0x3000 then 0x3004 drain in order.
- flush with in_valid (pc 0x3010, exc 5'd4, bd 1, data 0xDEAD) -> output shows data 0, pc 0x3010, exc 4, bd 1, out_bubble=1; bubble_cnt=1.
- req while occupancy=2 -> next cycle out_valid=0, out_pc=0x0000_4180, out_exc=0, occupancy=0, in_ready=1.
- req and flush together, and reset asserted mid-stall -> req/reset priority holds; counters follow their rules (hold under req, cleared by reset).
- Force stall_cnt to saturation (CNT_W=4, 20 stall cycles) -> stall_cnt=15 and holds.
